// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine reel stage.
package slot_pkg;

  typedef logic [3:0]      digit_t;
  typedef logic [5:0][3:0] slot_nums_t;

  // Digit code the display treats as blank; the reels never produce it.
  localparam digit_t      BLANK_DIGIT = 4'd10;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  // Reset reels 00 / 11 / 22 so a freshly reset machine never shows a win.
  localparam slot_nums_t  RESET_NUMS  = {4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};

endpackage

// File: rtl/reel_counter.sv
// One reel: run-gated prescaler plus a two-digit BCD register advanced by step.
module reel_counter
  import slot_pkg::*;
#(
  parameter int     TICK      = 4,
  parameter digit_t INIT_TENS = 4'd0,
  parameter digit_t INIT_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] step,
  output digit_t     tens,
  output digit_t     ones
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [4:0]    ones_sum;
  digit_t        ones_nxt;
  digit_t        tens_nxt;

  // A tick only exists while running, so a stop edge can never update the reel.
  assign tick = run && (cnt == CW'(TICK - 1));

  // BCD add of a 1 or 2 step: ones carries past 9, tens wraps 9 -> 0.
  always_comb begin
    ones_sum = {1'b0, ones} + {3'b000, step};
    ones_nxt = ones_sum[3:0];
    tens_nxt = tens;
    if (ones_sum > 5'd9) begin
      ones_nxt = 4'(ones_sum - 5'd10);
      tens_nxt = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end
  end

  // Prescaler clears while stopped so a restart waits a full TICK interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tens <= INIT_TENS;
      ones <= INIT_ONES;
    end else begin
      if (!run || tick) cnt <= '0;
      else              cnt <= cnt + 1'b1;
      if (tick) begin
        tens <= tens_nxt;
        ones <= ones_nxt;
      end
    end
  end

endmodule

// File: rtl/slot_reels.sv
// Reel generator: free-running LFSR picks per-reel steps, three prescaled
// BCD reels, and a free-running blink square wave for the FSM.
module slot_reels
  import slot_pkg::*;
#(
  parameter int          TICK0      = 5_000_000,
  parameter int          TICK1      = 3_700_000,
  parameter int          TICK2      = 2_900_000,
  parameter int          BLINK_HALF = 6_250_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slot_running,
  output slot_nums_t slot_nums,
  output logic       blink_clk
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [15:0]   lfsr;
  logic [BW-1:0] blink_cnt;

  // Galois LFSR steps every cycle; reels sample its pre-update bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr <= LFSR_SEED;
    else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    else              lfsr <= lfsr >> 1;
  end

  // Blink divider toggles every BLINK_HALF cycles, ignoring slot_running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_clk <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_clk <= ~blink_clk;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_reel
    localparam int T = (g == 0) ? TICK0 : ((g == 1) ? TICK1 : TICK2);
    reel_counter #(
      .TICK     (T),
      .INIT_TENS(RESET_NUMS[2*g+1]),
      .INIT_ONES(RESET_NUMS[2*g])
    ) u_reel (
      .clk  (clk),
      .rst_n(rst_n),
      .run  (slot_running),
      .step (2'd1 + {1'b0, lfsr[g]}),
      .tens (slot_nums[2*g+1]),
      .ones (slot_nums[2*g])
    );
  end

endmodule

// File: tb/tb_slot_reels.sv
// Randomized bench for slot_reels against an integer reel/LFSR model.
module tb_slot_reels;

  localparam int          T0   = 4;
  localparam int          T1   = 5;
  localparam int          T2   = 6;
  localparam int          BH   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            slot_running = 1'b0;
  logic [5:0][3:0] slot_nums;
  logic            blink_clk;

  always #5 clk = ~clk;

  slot_reels #(
    .TICK0(T0), .TICK1(T1), .TICK2(T2), .BLINK_HALF(BH), .LFSR_SEED(SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slot_running(slot_running),
    .slot_nums   (slot_nums),
    .blink_clk   (blink_clk)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: reel values as plain integers 0..99, run length, edge count.
  int          reel[3];
  int          tick_of[3] = '{T0, T1, T2};
  int          run_len;
  int          edges;
  logic [15:0] m_lfsr;
  bit          wrapped[3];
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    reel[0] = 0; reel[1] = 11; reel[2] = 22;
    run_len = 0;
    edges   = 0;
    m_lfsr  = SEED;
  endtask

  function automatic logic [23:0] model_nums();
    logic [5:0][3:0] v;
    for (int k = 0; k < 3; k++) begin
      v[2*k+1] = 4'(reel[k] / 10);
      v[2*k]   = 4'(reel[k] % 10);
    end
    return v;
  endfunction

  function automatic logic model_blink();
    return logic'((edges / BH) % 2);
  endfunction

  // One clock edge of the model, using the inputs held stable since the negedge.
  task automatic model_step(input logic run);
    int nv;
    edges++;
    if (run) begin
      run_len++;
      for (int k = 0; k < 3; k++)
        if (run_len % tick_of[k] == 0) begin
          nv = (reel[k] + 1 + int'(m_lfsr[k])) % 100;
          if (nv < reel[k]) wrapped[k] = 1'b1;
          reel[k] = nv;
        end
    end else begin
      run_len = 0;
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  always @(negedge rst_n) model_reset();

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    if (rst_n) model_step(slot_running);
    #1;
    if (checking) begin
      chk("slot_nums", 32'(slot_nums), 32'(model_nums()));
      chk("blink_clk", 32'(blink_clk), 32'(model_blink()));
      for (int d = 0; d < 6; d++)
        if (slot_nums[d] > 4'd9) chk("digit_range", 32'(slot_nums[d]), 32'd9);
    end
  end

  logic [23:0] exp_nums[6]  = '{24'h221100, 24'h221100, 24'h221100,
                                24'h221101, 24'h221301, 24'h241301};
  logic        exp_blink[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    model_reset();
    // Reset state and idle hold.
    repeat (3) @(posedge clk);
    #2;
    chk("reset_nums", 32'(slot_nums), 32'h221100);
    chk("reset_blink", 32'(blink_clk), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    checking = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    chk("idle_nums", 32'(slot_nums), 32'h221100);

    // Async reset between edges, then spin from the seed.
    @(negedge clk);
    #1 rst_n = 1'b0;
    slot_running = 1'b1;
    #1;
    chk("async_nums", 32'(slot_nums), 32'h221100);
    chk("async_blink", 32'(blink_clk), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk);
      #2;
      chk($sformatf("edge%0d_nums", e + 1), 32'(slot_nums), 32'(exp_nums[e]));
      chk($sformatf("edge%0d_blink", e + 1), 32'(blink_clk), 32'(exp_blink[e]));
    end

    // Freeze exactly on a would-be reel-0 tick, hold, then restart.
    repeat (37) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (run_len % T0 == T0 - 1) break;
    end
    slot_running = 1'b0;
    repeat (500) @(posedge clk);
    #2;
    chk("frozen_nums", 32'(slot_nums), 32'(model_nums()));
    @(negedge clk) slot_running = 1'b1;

    // Random run/stop stretches.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (slot_running) begin
        if ($urandom_range(0, 59) == 0) slot_running = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) slot_running = 1'b1;
      end
    end

    // Second async pulse mid-spin.
    slot_running = 1'b1;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async2_nums", 32'(slot_nums), 32'h221100);
    @(negedge clk) rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #2;

    for (int k = 0; k < 3; k++) chk($sformatf("wrap%0d", k), 32'(wrapped[k]), 32'd1);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_reels.md
# slot_reels

Upstream stage of the slot-machine FSM. It produces the three spinning two-digit BCD reel values that the FSM compares and displays, and the slow square wave the FSM uses as its blink clock. While `slot_running` is high, each reel advances at its own prescaled rate by a pseudo-random step of 1 or 2. When `slot_running` drops, all reels freeze on the same edge, so the FSM's STOP-state equality check sees final values only.

## Interface
- `TICK0`, default 5_000_000: clk cycles per reel-0 advance (≥2)
- `TICK1`, default 3_700_000: clk cycles per reel-1 advance (≥2)
- `TICK2`, default 2_900_000: clk cycles per reel-2 advance (≥2)
- `BLINK_HALF`, default 6_250_000: clk cycles per `blink_clk` half-period (≥1)
- `LFSR_SEED`, default 16'hACE1: LFSR reset value (nonzero)
- `clk`  in  1  system clock; the only clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `slot_running`  in  1  from FSM; high = reels spin
- `slot_nums`  out  [5:0][3:0]  reel k: tens digit = `[2k+1]`, ones digit = `[2k]`; BCD 0–9
- `blink_clk`  out  1  50%-duty square wave to FSM `blinkClk`

## Operation
- **LFSR:** 16-bit Galois, right-shift, steps every clk regardless of `slot_running`.
  - If `lfsr[0]`: `lfsr <= (lfsr>>1) ^ 16'hB400`.
  - Else: `lfsr <= lfsr>>1`.
- **Prescaler k:** counts `0..TICKk-1` while `slot_running`=1. `tick_k` is asserted when count == `TICKk-1` and `slot_running`=1; the count wraps to 0 on that tick. While `slot_running`=0, the count is held at 0.
- **Reel k on `tick_k`:** value <= (value + step_k) mod 100.
  - step_k = 1 + `lfsr[k]`, using the pre-update LFSR value from the same cycle.
  - Add in BCD: ones digit carries into tens at >9; tens wraps 9→0.
  - Wrap cases: 98+1=99, 99+1=00, 98+2=00, 99+2=01, 09+1=10, 19+2=21.
  - No digit ever exceeds 9; blank code 10 is never produced.
- **Reel hold:** reels change only on their own tick. Several reels ticking in the same cycle update independently.
- **Stop:** a cycle in which `slot_running`=0 never updates any reel, including a cycle that coincides with a would-be tick. Values are held indefinitely.
- **`blink_clk`:** a free-running divider toggles `blink_clk` when its count reaches `BLINK_HALF-1`, then wraps to 0. It is independent of `slot_running`.
- **Reset values:**
  - Reel 0 = 00, reel 1 = 11, reel 2 = 22, so `slot_nums` = {2,2,1,1,0,0} (index 5..0) and reset never presents a win.
  - `blink_clk`=0, LFSR=`LFSR_SEED`, all counters 0.

## Timing
- All state updates on posedge `clk`. Outputs are registered, with no combinational path from `slot_running` to the outputs.
- `slot_running` is sampled at each edge; the FSM drives it registered-synchronous to the same `clk`.
- First advance of reel k happens `TICKk` edges after the first edge that samples `slot_running`=1. Subsequent advances are every `TICKk` edges.
- Freeze latency is 0: the edge that samples `slot_running`=0 is already non-updating. The prescaler clears on that edge, so re-assertion restarts the full `TICKk` interval.
- `blink_clk` period is `2*BLINK_HALF` cycles; first rise at edge `BLINK_HALF` after reset release.
- Reset mid-operation:
  - Asserting `rst_n` immediately and asynchronously forces all reset values, independent of `clk`.
  - Release is synchronized externally; the first counted edge is the first edge with `rst_n`=1.

## Structure
- Package `slot_pkg`:
  - `digit_t` (`logic [3:0]`)
  - `slot_nums_t` (`logic [5:0][3:0]`)
  - `BLANK_DIGIT`=10, `LFSR_TAPS`=16'hB400
  - reset reel values
- Sub-module `reel_counter`, instantiated 3×: parameters `TICK`, `INIT_TENS`, `INIT_ONES`. It contains the prescaler and BCD register. Inputs `run`, `step`; outputs `tens`, `ones`.
- Top level holds the LFSR, the blink divider and the output packing.

## Test plan
- **Reset:** hold `rst_n`=0 → `slot_nums`={2,2,1,1,0,0}, `blink_clk`=0; release with `slot_running`=0 for 100 cycles → `slot_nums` unchanged.
- **Rates:** `TICK0/1/2`=4/5/6, `LFSR_SEED`=16'hACE1, `slot_running`=1 → reel 0 first changes at edge 4, reel 1 at edge 5, reel 2 at edge 6. Each step equals 1 + `lfsr[k]` from the reference LFSR model; compare every cycle for 2000 cycles.
- **Wrap:** run until each reel crosses 99 → observed sequences include 99→00 or 98→00/99→01. No digit >9 at any cycle.
- **Freeze:** deassert `slot_running` on the exact edge reel 0 would tick → no reel changes on that or any later edge for 500 cycles. Re-assert → reel 0 next changes exactly 4 edges later.
- **Blink:** `BLINK_HALF`=3 → `blink_clk` rises at edge 3, period 6, duty 3/3. Unchanged by toggling `slot_running`.
- **Async reset:** pulse `rst_n` low between clock edges mid-spin → outputs reach reset values before the next edge. Sequence restarts from `LFSR_SEED`.
